regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised successor of the single-port processor register file.
- Two registered read ports and one writeback-stage write port, with write-first bypass and an optional hardwired zero register.
- A per-register pending (scoreboard) bit is set when the decode stage issues an instruction targeting that register, and cleared on writeback.
- Read flags report RAW hazards to the pipeline stall logic.

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH, 32, number of registers; the index width is AW = $clog2(DEPTH), a derived localparam.
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and is never pending.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- readEnable  in  1  capture new read results this cycle
- rdIndexA  in  AW  read port A index
- rdIndexB  in  AW  read port B index
- rdValueA  out  WIDTH  registered read data A
- rdValueB  out  WIDTH  registered read data B
- rdFlagA  out  1  registered: register A still pending (hazard)
- rdFlagB  out  1  registered: register B still pending (hazard)
- writeEnable  in  1  global write enable
- regWriteW  in  1  writeback-stage write qualifier; a write occurs iff writeEnable && regWriteW
- wrIndex  in  AW  write index
- wrValue  in  WIDTH  write data
- issueEnable  in  1  mark issueIndex pending
- issueIndex  in  AW  destination register of the issued instruction
- pendingCount  out  AW+1  registered count of pending registers

Behaviour:
- Reset (async, rst_n=0):
  - all registers, pending bits, rdValueA/B, rdFlagA/B and pendingCount go to 0 immediately.
  - Reset held across clock edges blocks all writes, issues and reads.
  - Release takes effect at the first posedge with rst_n=1.
- Write (qualified write = writeEnable && regWriteW, at posedge):
  - mem[wrIndex] <= wrValue.
  - pending[wrIndex] <= 0, unless overridden by an issue (see below).
  - Ignored if ZERO_REG && wrIndex==0, or if wrIndex >= DEPTH.
  - writeEnable=1 with regWriteW=0: no write, no pending clear.
- Issue (issueEnable=1, at posedge): pending[issueIndex] <= 1. Ignored for the zero register (ZERO_REG=1) or for issueIndex >= DEPTH.
- Simultaneous write and issue to the same index: the write updates data, and pending ends at 1 because the new producer wins.
- Read (1-cycle latency):
  - At a posedge with readEnable=1, each port captures the value and flag of its index.
  - Value: wrValue if a qualified write targets the same index this cycle (bypass), else mem[idx].
  - Flag: the pending state after this cycle's updates, i.e. (pending[idx] && !write-clear) || same-cycle issue to idx.
  - Index 0 with ZERO_REG=1, or idx >= DEPTH: value 0, flag 0.
  - readEnable=0: rdValue*/rdFlag* hold their previous values.
  - Ports A and B are independent and may use the same index.
- pendingCount: updated every posedge to the popcount of the next-state pending vector. Range 0..DEPTH, or 0..DEPTH-1 with ZERO_REG=1.
- No combinational path from any input to any output; all outputs are flops.

Test Plan:
- Reset, then write 32'h0002_0000 to r1 with writeEnable=regWriteW=1; read A=r1 with readEnable=1 on the next cycle -> rdValueA=32'h0002_0000 one cycle later, rdFlagA=0.
- In a single cycle, write 32'hDEAD_BEEF to r5 and read A=B=r5 -> both ports show 32'hDEAD_BEEF (bypass) after one cycle, and both flags = 0.
- Write 32'hFFFF_FFFF to r0, then read r0 -> rdValueA=0; issue r0 -> pendingCount stays 0.
- Issue r3 and r7 -> pendingCount=2. Then read r3 -> rdFlagA=1. Then write r3=32'h11 -> pendingCount=1, and a re-read of r3 gives value 32'h11 with flag 0.
- Issue r4 and write r4=32'h22 in the same cycle, with a same-cycle read of r4 -> rdValueA=32'h22, rdFlagA=1, pendingCount=1.
- Pulse rst_n low mid-clock while r2 is pending and rdValueA≠0 -> outputs and pendingCount go to 0 without waiting for a clock edge, and a later read of r2 returns 0 with flag 0. Also, writeEnable=1 with regWriteW=0 to r6 -> r6 is unchanged.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// Pipeline-side bundle for the register file scoreboard: read, writeback and issue
// requests from the pipeline, registered read results and the pending count back.
interface regfile_scoreboard_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32
);
   localparam int AW = $clog2(DEPTH);

   logic             readEnable;
   logic [AW-1:0]    rdIndexA;
   logic [AW-1:0]    rdIndexB;
   logic [WIDTH-1:0] rdValueA;
   logic [WIDTH-1:0] rdValueB;
   logic             rdFlagA;
   logic             rdFlagB;
   logic             writeEnable;
   logic             regWriteW;
   logic [AW-1:0]    wrIndex;
   logic [WIDTH-1:0] wrValue;
   logic             issueEnable;
   logic [AW-1:0]    issueIndex;
   logic [AW:0]      pendingCount;

   modport master (
      output readEnable, rdIndexA, rdIndexB, writeEnable, regWriteW,
             wrIndex, wrValue, issueEnable, issueIndex,
      input  rdValueA, rdValueB, rdFlagA, rdFlagB, pendingCount
   );

   modport slave (
      input  readEnable, rdIndexA, rdIndexB, writeEnable, regWriteW,
             wrIndex, wrValue, issueEnable, issueIndex,
      output rdValueA, rdValueB, rdFlagA, rdFlagB, pendingCount
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with write-first bypass, optional zero register
// and a per-register pending scoreboard reporting RAW hazards; all outputs registered.
module regfile_scoreboard #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int ZERO_REG = 1
) (
   input logic                 clk,
   input logic                 rst_n,
   regfile_scoreboard_if.slave bus
);
   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [DEPTH-1:0] pend_r;
   logic [DEPTH-1:0] pend_next_s;
   logic             wr_ok_s;
   logic             iss_ok_s;
   logic [WIDTH-1:0] rd_val_a_s;
   logic [WIDTH-1:0] rd_val_b_s;
   logic             rd_flag_a_s;
   logic             rd_flag_b_s;
   logic [WIDTH-1:0] rd_value_a_r;
   logic [WIDTH-1:0] rd_value_b_r;
   logic             rd_flag_a_r;
   logic             rd_flag_b_r;
   logic [AW:0]      pend_cnt_r;

   // An index is usable when it exists and is not the hardwired zero register.
   function automatic logic idx_ok(input logic [AW-1:0] idx);
      logic ok;
      ok = ({1'b0, idx} < DEPTH_W);
      if ((ZERO_REG != 0) && (idx == {AW{1'b0}})) begin
         ok = 1'b0;
      end else begin
         ok = ok;
      end
      return ok;
   endfunction

   function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
      logic [AW:0] cnt;
      cnt = {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         cnt = cnt + (AW+1)'(v[i]);
      end
      return cnt;
   endfunction

   // Qualified requests and next pending vector; a same-cycle issue beats the writeback clear.
   always_comb begin
      wr_ok_s  = bus.writeEnable && bus.regWriteW && idx_ok(bus.wrIndex);
      iss_ok_s = bus.issueEnable && idx_ok(bus.issueIndex);
      pend_next_s = {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         pend_next_s[i] = (pend_r[i] && !(wr_ok_s && (bus.wrIndex == AW'(i))))
                        || (iss_ok_s && (bus.issueIndex == AW'(i)));
      end
   end

   // Read-port data with write-first bypass; flags see the post-update pending state.
   always_comb begin
      rd_val_a_s  = {WIDTH{1'b0}};
      rd_val_b_s  = {WIDTH{1'b0}};
      rd_flag_a_s = 1'b0;
      rd_flag_b_s = 1'b0;
      if (!idx_ok(bus.rdIndexA)) begin
         rd_val_a_s = {WIDTH{1'b0}};
      end else if (wr_ok_s && (bus.wrIndex == bus.rdIndexA)) begin
         rd_val_a_s  = bus.wrValue;
         rd_flag_a_s = pend_next_s[bus.rdIndexA];
      end else begin
         rd_val_a_s  = mem_r[bus.rdIndexA];
         rd_flag_a_s = pend_next_s[bus.rdIndexA];
      end
      if (!idx_ok(bus.rdIndexB)) begin
         rd_val_b_s = {WIDTH{1'b0}};
      end else if (wr_ok_s && (bus.wrIndex == bus.rdIndexB)) begin
         rd_val_b_s  = bus.wrValue;
         rd_flag_b_s = pend_next_s[bus.rdIndexB];
      end else begin
         rd_val_b_s  = mem_r[bus.rdIndexB];
         rd_flag_b_s = pend_next_s[bus.rdIndexB];
      end
   end

   // Register storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else if (wr_ok_s) begin
         mem_r[bus.wrIndex] <= bus.wrValue;
      end
   end

   // Scoreboard state, pending count and registered read results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_r       <= {DEPTH{1'b0}};
         pend_cnt_r   <= {(AW+1){1'b0}};
         rd_value_a_r <= {WIDTH{1'b0}};
         rd_value_b_r <= {WIDTH{1'b0}};
         rd_flag_a_r  <= 1'b0;
         rd_flag_b_r  <= 1'b0;
      end else begin
         pend_r     <= pend_next_s;
         pend_cnt_r <= popcount(pend_next_s);
         if (bus.readEnable) begin
            rd_value_a_r <= rd_val_a_s;
            rd_value_b_r <= rd_val_b_s;
            rd_flag_a_r  <= rd_flag_a_s;
            rd_flag_b_r  <= rd_flag_b_s;
         end
      end
   end

   assign bus.rdValueA     = rd_value_a_r;
   assign bus.rdValueB     = rd_value_b_r;
   assign bus.rdFlagA      = rd_flag_a_r;
   assign bus.rdFlagB      = rd_flag_b_r;
   assign bus.pendingCount = pend_cnt_r;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a behavioural register-file model checked
// every negedge, plus hand-computed checks from the test plan.
module tb_regfile_scoreboard;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;
   bit   checking = 1'b0;

   regfile_scoreboard_if #(.WIDTH(32), .DEPTH(32)) bus ();

   regfile_scoreboard #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural model: apply this cycle's updates, then reads observe the result.
   logic [31:0] m_mem [32];
   bit          m_pend [32];
   logic [31:0] exp_a = 32'h0, exp_b = 32'h0;
   logic        exp_fa = 1'b0, exp_fb = 1'b0;
   int          exp_cnt = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            m_mem[i] = 32'h0;
            m_pend[i] = 1'b0;
         end
         exp_a = 32'h0; exp_b = 32'h0; exp_fa = 1'b0; exp_fb = 1'b0; exp_cnt = 0;
      end else begin
         if (bus.writeEnable && bus.regWriteW && bus.wrIndex != 5'd0) begin
            m_mem[bus.wrIndex] = bus.wrValue;
            m_pend[bus.wrIndex] = 1'b0;
         end
         if (bus.issueEnable && bus.issueIndex != 5'd0)
            m_pend[bus.issueIndex] = 1'b1;
         if (bus.readEnable) begin
            exp_a  = m_mem[bus.rdIndexA];
            exp_b  = m_mem[bus.rdIndexB];
            exp_fa = m_pend[bus.rdIndexA];
            exp_fb = m_pend[bus.rdIndexB];
         end
         exp_cnt = 0;
         for (int i = 0; i < 32; i++) exp_cnt += int'(m_pend[i]);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (checking) begin
         chk("model_valA",  bus.rdValueA, exp_a);
         chk("model_valB",  bus.rdValueB, exp_b);
         chk("model_flagA", 32'(bus.rdFlagA), 32'(exp_fa));
         chk("model_flagB", 32'(bus.rdFlagB), 32'(exp_fb));
         chk("model_count", 32'(bus.pendingCount), 32'(exp_cnt));
      end
   end

   task automatic idle();
      bus.readEnable  = 1'b0;
      bus.writeEnable = 1'b0;
      bus.regWriteW   = 1'b0;
      bus.issueEnable = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] idx, input logic [31:0] val);
      bus.writeEnable = 1'b1;
      bus.regWriteW   = 1'b1;
      bus.wrIndex     = idx;
      bus.wrValue     = val;
   endtask

   task automatic rd(input logic [4:0] a, input logic [4:0] b);
      bus.readEnable = 1'b1;
      bus.rdIndexA   = a;
      bus.rdIndexB   = b;
   endtask

   task automatic iss(input logic [4:0] idx);
      bus.issueEnable = 1'b1;
      bus.issueIndex  = idx;
   endtask

   initial begin
      idle();
      bus.rdIndexA = 5'd0; bus.rdIndexB = 5'd0; bus.wrIndex = 5'd0;
      bus.wrValue = 32'h0; bus.issueIndex = 5'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valA", bus.rdValueA, 32'h0);
      chk("reset_count", 32'(bus.pendingCount), 32'h0);
      rst_n = 1'b1;
      checking = 1'b1;

      // write r1, read next cycle
      wr(5'd1, 32'h0002_0000); tick();
      idle(); rd(5'd1, 5'd0); tick();
      chk("r1_val", bus.rdValueA, 32'h0002_0000);
      chk("r1_flag", 32'(bus.rdFlagA), 32'h0);

      // bypass on both ports
      idle(); wr(5'd5, 32'hDEAD_BEEF); rd(5'd5, 5'd5); tick();
      chk("byp_valA", bus.rdValueA, 32'hDEAD_BEEF);
      chk("byp_valB", bus.rdValueB, 32'hDEAD_BEEF);
      chk("byp_flags", 32'({bus.rdFlagA, bus.rdFlagB}), 32'h0);

      // zero register
      idle(); wr(5'd0, 32'hFFFF_FFFF); tick();
      idle(); rd(5'd0, 5'd0); tick();
      chk("r0_val", bus.rdValueA, 32'h0);
      idle(); iss(5'd0); tick();
      chk("r0_issue_count", 32'(bus.pendingCount), 32'h0);

      // scoreboard set/clear
      idle(); iss(5'd3); tick();
      iss(5'd7); tick();
      chk("count_two", 32'(bus.pendingCount), 32'd2);
      idle(); rd(5'd3, 5'd0); tick();
      chk("r3_pending", 32'(bus.rdFlagA), 32'h1);
      idle(); wr(5'd3, 32'h11); tick();
      chk("count_after_wb", 32'(bus.pendingCount), 32'd1);
      chk("hold_valA", bus.rdValueA, 32'h0);
      idle(); rd(5'd3, 5'd0); tick();
      chk("r3_val", bus.rdValueA, 32'h11);
      chk("r3_flag", 32'(bus.rdFlagA), 32'h0);
      idle(); rd(5'd3, 5'd5); tick();
      chk("split_valA", bus.rdValueA, 32'h11);
      chk("split_valB", bus.rdValueB, 32'hDEAD_BEEF);
      idle(); wr(5'd7, 32'h77); tick();

      // write and issue same register, same-cycle read
      idle(); iss(5'd4); wr(5'd4, 32'h22); rd(5'd4, 5'd0); tick();
      chk("r4_val", bus.rdValueA, 32'h22);
      chk("r4_flag", 32'(bus.rdFlagA), 32'h1);
      chk("r4_count", 32'(bus.pendingCount), 32'd1);

      // asynchronous reset mid-cycle
      idle(); iss(5'd2); tick();
      idle();
      #2 rst_n = 1'b0;
      #1;
      chk("async_valA", bus.rdValueA, 32'h0);
      chk("async_flagA", 32'(bus.rdFlagA), 32'h0);
      chk("async_count", 32'(bus.pendingCount), 32'h0);
      wr(5'd9, 32'h99); iss(5'd9); rd(5'd9, 5'd9);
      tick();
      chk("held_reset_count", 32'(bus.pendingCount), 32'h0);
      chk("held_reset_valA", bus.rdValueA, 32'h0);
      idle(); rst_n = 1'b1;
      rd(5'd2, 5'd9); tick();
      chk("r2_after_rst_val", bus.rdValueA, 32'h0);
      chk("r2_after_rst_flag", 32'(bus.rdFlagA), 32'h0);
      chk("r9_after_rst_val", bus.rdValueB, 32'h0);

      // unqualified write neither writes nor clears pending
      idle(); wr(5'd6, 32'h66); tick();
      idle(); iss(5'd6); tick();
      idle(); bus.writeEnable = 1'b1; bus.regWriteW = 1'b0;
      bus.wrIndex = 5'd6; bus.wrValue = 32'h99; tick();
      idle(); rd(5'd6, 5'd6); tick();
      chk("r6_val", bus.rdValueA, 32'h66);
      chk("r6_flag", 32'(bus.rdFlagB), 32'h1);

      idle(); tick(); tick();
      checking = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
